// File: rtl/checkbits_seq_monitor.sv
// rtl/checkbits_seq_monitor.sv - start/sequence/end code monitor for a parallel status word
//
// Purpose: waits for START_CODE on obs, then walks a programmed table of
// expected values (wait-for or strict ordering), then waits for END_CODE.
// Reports pass/fail, the failure cause, per-entry match strobes and a
// saturating cycle count since arm. Each busy step has a programmable timeout.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   obs               observed status word, sampled every cycle
//   cfg_we/addr/data  table write port, ignored while busy
//   cfg_len           number of table entries to check (0..DEPTH), captured on arm
//   timeout_cycles    cycles without progress before failing, 0 = never; captured on arm
//   strict            0 = wait-for (level) matching, 1 = strict (change-event) matching
//   arm               one-cycle pulse that starts or restarts a check from any state
//   busy/done/pass    status flags decoded from the registered state
//   fail_code         0 none, 1 start timeout, 2 step timeout, 3 mismatch, 4 end timeout
//   match_pulse       one-cycle strobe per matched entry
//   match_idx         index of the last matched entry
//   cycle_count       busy cycles since arm, saturating, frozen in PASS/FAIL
module checkbits_seq_monitor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 24,
  parameter logic [DATA_W-1:0] START_CODE = 16'hAB40,
  parameter logic [DATA_W-1:0] END_CODE = 16'hAB51,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned LEN_W = IDX_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] obs,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic              strict,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic              match_pulse,
  output logic [IDX_W-1:0]  match_idx,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_RUN, S_WAIT_END, S_PASS, S_FAIL
  } state_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_START_TO = 3'd1;
  localparam logic [2:0] FC_STEP_TO  = 3'd2;
  localparam logic [2:0] FC_MISMATCH = 3'd3;
  localparam logic [2:0] FC_END_TO   = 3'd4;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tbl_q [DEPTH];
  logic [DATA_W-1:0] obs_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  timer_q;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  timeout_q;
  logic [LEN_W-1:0]  len_q;
  logic              strict_q;
  logic [2:0]        fail_q, fail_d;
  logic              pulse_q;
  logic [IDX_W-1:0]  midx_q;

  logic              busy_w;
  logic              change;
  logic              expire;
  logic              start_det;
  logic              hit;
  logic              miss;
  logic              last;
  logic [DATA_W-1:0] exp_val;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; also produces the progress/failure events the datapath uses
  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    start_det = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    change    = (obs != obs_q);
    exp_val   = tbl_q[idx_q];
    last      = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);
    // Expiry fires on the last allowed cycle; progress in that same cycle takes priority below
    expire    = (timeout_q != '0) && (timer_q == timeout_q - CNT_W'(1));
    if (arm) begin
      state_d = S_WAIT_START;
      fail_d  = FC_NONE;
    end else begin
      case (state_q)
        S_WAIT_START: begin
          if (obs == START_CODE) begin
            start_det = 1'b1;
            state_d   = (len_q == '0) ? S_WAIT_END : S_RUN;
          end else if (expire) begin
            state_d = S_FAIL;
            fail_d  = FC_START_TO;
          end
        end
        S_RUN: begin
          // Strict mode needs a fresh value; a return to START_CODE never counts as progress
          hit  = strict_q ? (change && (obs == exp_val) && (obs != START_CODE))
                          : (obs == exp_val);
          miss = strict_q && change && !hit;
          if (hit) begin
            if (last) state_d = S_WAIT_END;
          end else if (miss) begin
            state_d = S_FAIL;
            fail_d  = FC_MISMATCH;
          end else if (expire) begin
            state_d = S_FAIL;
            fail_d  = FC_STEP_TO;
          end
        end
        S_WAIT_END: begin
          if (obs == END_CODE) begin
            state_d = S_PASS;
          end else if (strict_q && change) begin
            state_d = S_FAIL;
            fail_d  = FC_MISMATCH;
          end else if (expire) begin
            state_d = S_FAIL;
            fail_d  = FC_END_TO;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    busy_w      = (state_q == S_WAIT_START) || (state_q == S_RUN) || (state_q == S_WAIT_END);
    busy        = busy_w;
    done        = (state_q == S_PASS) || (state_q == S_FAIL);
    pass        = (state_q == S_PASS);
    fail_code   = fail_q;
    match_pulse = pulse_q;
    match_idx   = midx_q;
    cycle_count = cycle_q;
  end

  // Datapath: sampled obs, step index, timers, captured configuration, status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      obs_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      cycle_q   <= '0;
      timeout_q <= '0;
      len_q     <= '0;
      strict_q  <= 1'b0;
      fail_q    <= FC_NONE;
      pulse_q   <= 1'b0;
      midx_q    <= '0;
    end else begin
      obs_q   <= obs;
      pulse_q <= 1'b0;
      if (arm) begin
        idx_q     <= '0;
        timer_q   <= '0;
        cycle_q   <= '0;
        fail_q    <= FC_NONE;
        midx_q    <= '0;
        timeout_q <= timeout_cycles;
        strict_q  <= strict;
        len_q     <= (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
      end else begin
        fail_q <= fail_d;
        if (busy_w) begin
          if (!(&cycle_q)) cycle_q <= cycle_q + CNT_W'(1);
          timer_q <= (start_det || hit) ? '0 : timer_q + CNT_W'(1);
        end
        if (start_det) idx_q <= '0;
        if (hit) begin
          pulse_q <= 1'b1;
          midx_q  <= idx_q;
          idx_q   <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Expected-value table; deliberately not reset so contents survive a reset
  always_ff @(posedge clock) begin
    if (cfg_we && !busy_w && (32'(cfg_addr) < DEPTH)) tbl_q[cfg_addr] <= cfg_data;
  end

endmodule
